// File: rtl/shadow_pkg.sv
// Shared types for the shadow context sequencer: FSM state encoding and the
// first register index that takes part in a copy.
package shadow_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // x0 is hardwired in the main register file, so copies start at register 1.
  localparam int unsigned FIRST_IDX = 1;

endpackage

// File: rtl/shadow_ctx_sequencer.sv
// Copies the main register file into the shadow bank on interrupt entry and
// back on return, one register per cycle, stalling the pipeline meanwhile.
module shadow_ctx_sequencer
  import shadow_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       save_req,
  input  logic                       restore_req,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       shadow_valid,
  output logic [$clog2(REG_NUM)-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]      rf_rd_data,
  output logic [$clog2(REG_NUM)-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0]      rf_wr_data,
  output logic                       rf_wr_en,
  output logic [$clog2(REG_NUM)-1:0] sh_write_addr,
  output logic [DATA_WIDTH-1:0]      sh_data_in,
  output logic                       sh_write_en,
  output logic [$clog2(REG_NUM)-1:0] sh_read_addr,
  input  logic [DATA_WIDTH-1:0]      sh_data_out
);

  localparam int AW = $clog2(REG_NUM);
  localparam logic [AW-1:0] IDX_FIRST = AW'(FIRST_IDX);
  localparam logic [AW-1:0] IDX_LAST  = AW'(REG_NUM - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic          op_save;

  // Control FSM; op_save remembers which copy is finishing so DONE can
  // update shadow_valid on its way back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      op_save      <= 1'b0;
      shadow_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (save_req) begin
            state   <= S_SAVE;
            idx     <= IDX_FIRST;
            op_save <= 1'b1;
          end else if (restore_req) begin
            if (shadow_valid) begin
              state   <= S_RESTORE;
              idx     <= IDX_FIRST;
              op_save <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_SAVE, S_RESTORE: begin
          if (idx == IDX_LAST) begin
            state <= S_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          shadow_valid <= op_save;
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  logic in_save;
  logic in_restore;

  // Datapath steering is a pure decode of state and idx; requests never
  // reach the outputs combinationally.
  always_comb begin
    in_save    = (state == S_SAVE);
    in_restore = (state == S_RESTORE);

    busy = (state != S_IDLE);
    done = (state == S_DONE);

    rf_rd_addr    = in_save ? idx : '0;
    sh_write_addr = in_save ? idx : '0;
    sh_data_in    = in_save ? rf_rd_data : '0;
    sh_write_en   = in_save;

    sh_read_addr = in_restore ? idx : '0;
    rf_wr_addr   = in_restore ? idx : '0;
    rf_wr_data   = in_restore ? sh_data_out : '0;
    rf_wr_en     = in_restore;
  end

  // x0 must never be addressed while a copy is running.
  assert property (@(posedge clk) disable iff (reset)
    (state == S_SAVE || state == S_RESTORE) |-> (idx != '0));

endmodule

// File: tb/tb_shadow_ctx_sequencer.sv
// Directed bench for shadow_ctx_sequencer with behavioural main register file
// (rising-edge write) and shadow bank (falling-edge write).
module tb_shadow_ctx_sequencer;

  localparam int REG_NUM    = 32;
  localparam int DATA_WIDTH = 64;
  localparam int AW         = $clog2(REG_NUM);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  save_req;
  logic                  restore_req;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  shadow_valid;
  logic [AW-1:0]         rf_rd_addr;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic [AW-1:0]         rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_wr_en;
  logic [AW-1:0]         sh_write_addr;
  logic [DATA_WIDTH-1:0] sh_data_in;
  logic                  sh_write_en;
  logic [AW-1:0]         sh_read_addr;
  logic [DATA_WIDTH-1:0] sh_data_out;

  shadow_ctx_sequencer #(.REG_NUM(REG_NUM), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .err(err), .shadow_valid(shadow_valid),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
    .sh_write_addr(sh_write_addr), .sh_data_in(sh_data_in),
    .sh_write_en(sh_write_en), .sh_read_addr(sh_read_addr),
    .sh_data_out(sh_data_out)
  );

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] rf     [REG_NUM];
  logic [DATA_WIDTH-1:0] shadow [REG_NUM];
  int rf_wr_cnt = 0, rf_x0_cnt = 0, sh_wr_cnt = 0, sh_x0_cnt = 0;

  assign rf_rd_data  = rf[rf_rd_addr];
  assign sh_data_out = shadow[sh_read_addr];

  always @(posedge clk) begin
    if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_data;
      rf_wr_cnt++;
      if (rf_wr_addr == '0) rf_x0_cnt++;
    end
  end

  always @(negedge clk) begin
    if (sh_write_en) begin
      shadow[sh_write_addr] <= sh_data_in;
      sh_wr_cnt++;
      if (sh_write_addr == '0) sh_x0_cnt++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the current (busy) cycle until the first idle cycle.
  task automatic wait_idle(output int cyc, output int done_at, output int ndone);
    cyc = 0; done_at = -1; ndone = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) begin
        ndone++;
        done_at = cyc;
      end
      tick();
    end
    check("idle_timeout", 64'(cyc < 100), 64'd1);
  endtask

  function automatic logic [63:0] pat_a(input int i);
    return 64'(i) * 64'h1111;
  endfunction

  function automatic logic [63:0] pat_b(input int i);
    return 64'h0123_4567_0000_0000 | 64'(i);
  endfunction

  int cyc, done_at, ndone, rf0, sh0, guard;

  initial begin
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      rf[i]     = (i == 0) ? 64'hA5A5_A5A5 : pat_a(i);
      shadow[i] = 64'hFFFF_0000_FFFF_0000;
    end
    tick(); tick();

    // Reset state
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_valid", 64'(shadow_valid), 0);
    check("rst_addrs", 64'({rf_rd_addr, rf_wr_addr, sh_write_addr, sh_read_addr}), 0);
    check("rst_wens", 64'({rf_wr_en, sh_write_en}), 0);
    check("rst_data", rf_wr_data | sh_data_in, 0);
    reset = 1'b0;
    tick();

    // Restore without a saved context
    rf0 = rf_wr_cnt; sh0 = sh_wr_cnt;
    restore_req = 1'b1;
    check("nosave_err_early", 64'(err), 0);
    tick();
    restore_req = 1'b0;
    check("nosave_err", 64'(err), 1);
    check("nosave_busy", 64'(busy), 0);
    tick();
    check("nosave_err_clr", 64'(err), 0);
    check("nosave_busy2", 64'(busy), 0);
    check("nosave_writes", 64'((rf_wr_cnt - rf0) + (sh_wr_cnt - sh0)), 0);

    // Save
    sh0 = sh_wr_cnt;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    check("save_busy", 64'(busy), 1);
    check("save_rd_addr", 64'(rf_rd_addr), 1);
    check("save_sh_wen", 64'(sh_write_en), 1);
    check("save_rf_wen", 64'(rf_wr_en), 0);
    wait_idle(cyc, done_at, ndone);
    check("save_busy_cycles", 64'(cyc), 32);
    check("save_done_at", 64'(done_at), 32);
    check("save_done_cnt", 64'(ndone), 1);
    check("save_valid", 64'(shadow_valid), 1);
    check("save_sh_writes", 64'(sh_wr_cnt - sh0), 31);
    check("save_sh_x0", 64'(sh_x0_cnt), 0);
    check("save_shadow0", shadow[0], 64'hFFFF_0000_FFFF_0000);
    for (int i = 1; i < REG_NUM; i++) check($sformatf("save_shadow%0d", i), shadow[i], pat_a(i));

    // Restore round trip
    for (int i = 0; i < REG_NUM; i++) rf[i] = 64'hDEAD;
    rf0 = rf_wr_cnt;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check("rest_busy", 64'(busy), 1);
    check("rest_wr_addr", 64'(rf_wr_addr), 1);
    check("rest_rf_wen", 64'(rf_wr_en), 1);
    check("rest_sh_wen", 64'(sh_write_en), 0);
    wait_idle(cyc, done_at, ndone);
    check("rest_busy_cycles", 64'(cyc), 32);
    check("rest_done_at", 64'(done_at), 32);
    check("rest_valid", 64'(shadow_valid), 0);
    check("rest_rf_writes", 64'(rf_wr_cnt - rf0), 31);
    check("rest_rf_x0", 64'(rf_x0_cnt), 0);
    check("rest_rf0", rf[0], 64'hDEAD);
    for (int i = 1; i < REG_NUM; i++) check($sformatf("rest_rf%0d", i), rf[i], pat_a(i));

    // Second restore of the same context is rejected
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check("rest_twice_err", 64'(err), 1);
    check("rest_twice_busy", 64'(busy), 0);
    tick();

    // Simultaneous requests: save wins, mid-save restore ignored
    rf0 = rf_wr_cnt;
    save_req = 1'b1; restore_req = 1'b1;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    check("sim_busy", 64'(busy), 1);
    check("sim_sh_wen", 64'(sh_write_en), 1);
    check("sim_err", 64'(err), 0);
    tick(); tick(); tick();
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_idle(cyc, done_at, ndone);
    check("sim_busy_cycles", 64'(cyc), 28);
    check("sim_valid", 64'(shadow_valid), 1);
    tick();
    check("sim_no_restore", 64'(busy), 0);
    check("sim_rf_writes", 64'(rf_wr_cnt - rf0), 0);

    // Reset mid-save
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    guard = 0;
    while (rf_rd_addr != AW'(10) && guard < 40) begin
      tick();
      guard++;
    end
    check("midrst_idx", 64'(rf_rd_addr), 10);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_valid", 64'(shadow_valid), 0);
    check("midrst_sh_wen", 64'(sh_write_en), 0);
    tick();
    reset = 1'b0;
    tick();
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check("midrst_err", 64'(err), 1);
    check("midrst_err_busy", 64'(busy), 0);
    tick();

    // Back-to-back saves
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    wait_idle(cyc, done_at, ndone);
    check("b2b_first_cycles", 64'(cyc), 32);
    for (int i = 1; i < REG_NUM; i++) rf[i] = pat_b(i);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    check("b2b_second_busy", 64'(busy), 1);
    wait_idle(cyc, done_at, ndone);
    check("b2b_second_cycles", 64'(cyc), 32);
    check("b2b_valid", 64'(shadow_valid), 1);
    check("b2b_shadow1", shadow[1], pat_b(1));
    check("b2b_shadow16", shadow[16], pat_b(16));
    check("b2b_shadow31", shadow[31], pat_b(31));
    check("b2b_sh_x0", 64'(sh_x0_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
